mlaccel_accum: RTL

MLACCEL_ACCUM -- requirements
Module: mlaccel_accum

---
 rtl/mlaccel_accum.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mlaccel_accum.sv
// rtl/mlaccel_accum.sv - two-stage MAC/max accumulator bank with saturating store FIFO
module mlaccel_accum #(
   parameter int NCH    = 2,
   parameter int NPROD  = 8,
   parameter int PW     = 16,
   parameter int ODEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              in_op,
   input  logic [NCH-1:0]          in_chmask,
   input  logic [4:0]              in_shift,
   input  logic                    in_relu,
   input  logic [NCH*NPROD*PW-1:0] in_prod,
   input  logic [NCH*32-1:0]       in_ldata,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NCH*8-1:0]        out_data,
   output logic [NCH-1:0]          out_bmask,
   output logic                    busy
);
   localparam int AW = $clog2(ODEPTH);
   localparam logic [AW+1:0] DEPTH_W = ODEPTH[AW+1:0];

   typedef enum logic [2:0] {
      OP_MACC  = 3'd0,
      OP_MACCZ = 3'd1,
      OP_MMAX  = 3'd2,
      OP_MMAXZ = 3'd3,
      OP_LDSET = 3'd4,
      OP_LDADD = 3'd5,
      OP_LDMAX = 3'd6,
      OP_STORE = 3'd7
   } op_t;

   logic               s1_valid;
   op_t                s1_op;
   logic [NCH-1:0]     s1_mask;
   logic [4:0]         s1_shift;
   logic               s1_relu;
   logic signed [31:0] s1_ldata [NCH];
   logic signed [31:0] s1_sum   [NCH];
   logic signed [31:0] s1_max   [NCH];

   logic               s2_valid;
   op_t                s2_op;
   logic [NCH-1:0]     s2_mask;
   logic [4:0]         s2_shift;
   logic               s2_relu;
   logic signed [31:0] s2_opnd  [NCH];

   logic signed [31:0] acc      [NCH];
   logic signed [31:0] acc_next [NCH];

   logic [NCH*8-1:0]   fifo_data [ODEPTH];
   logic [NCH-1:0]     fifo_mask [ODEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [AW:0]        count;

   logic               accept;
   logic               s1_store;
   logic               s2_store;
   logic               push;
   logic               pop;
   logic [AW+1:0]      reserved;

   logic signed [31:0] sum_c [NCH];
   logic signed [31:0] max_c [NCH];
   logic signed [PW-1:0] p_raw;
   logic signed [31:0] prod_x;
   logic signed [31:0] shifted;
   logic [NCH*8-1:0]   store_bytes;

   // Every STORE in flight already owns a FIFO slot, so the pipeline itself never stalls
   assign s1_store  = s1_valid && (s1_op == OP_STORE);
   assign s2_store  = s2_valid && (s2_op == OP_STORE);
   assign reserved  = {1'b0, count} + {{(AW+1){1'b0}}, s1_store} + {{(AW+1){1'b0}}, s2_store};
   assign in_ready  = !reset && (reserved < DEPTH_W);
   assign accept    = in_valid && in_ready;
   assign push      = s2_store;
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = fifo_data[rd_ptr];
   assign out_bmask = fifo_mask[rd_ptr];
   assign busy      = s1_valid || s2_valid || out_valid;

   // Reduce each channel's products to a wrapping 32-bit sum and a signed maximum
   always_comb begin
      p_raw  = '0;
      prod_x = '0;
      for (int c = 0; c < NCH; c++) begin
         sum_c[c] = '0;
         p_raw    = in_prod[c*NPROD*PW +: PW];
         max_c[c] = 32'(p_raw);
         for (int i = 0; i < NPROD; i++) begin
            p_raw    = in_prod[(c*NPROD+i)*PW +: PW];
            prod_x   = 32'(p_raw);
            sum_c[c] = sum_c[c] + prod_x;
            if (prod_x > max_c[c]) max_c[c] = prod_x;
         end
      end
   end

   // S1: capture the accepted command together with its product reductions
   always_ff @(posedge clock) begin
      if (reset) s1_valid <= 1'b0;
      else       s1_valid <= accept;
      if (accept) begin
         s1_op    <= op_t'(in_op);
         s1_mask  <= in_chmask;
         s1_shift <= in_shift;
         s1_relu  <= in_relu;
         for (int c = 0; c < NCH; c++) begin
            s1_ldata[c] <= in_ldata[32*c +: 32];
            s1_sum[c]   <= sum_c[c];
            s1_max[c]   <= max_c[c];
         end
      end
   end

   // S2: carry the command forward with only the operand its opcode needs
   always_ff @(posedge clock) begin
      if (reset) s2_valid <= 1'b0;
      else       s2_valid <= s1_valid;
      s2_op    <= s1_op;
      s2_mask  <= s1_mask;
      s2_shift <= s1_shift;
      s2_relu  <= s1_relu;
      for (int c = 0; c < NCH; c++) begin
         case (s1_op)
            OP_MACC, OP_MACCZ: s2_opnd[c] <= s1_sum[c];
            OP_MMAX, OP_MMAXZ: s2_opnd[c] <= s1_max[c];
            default:           s2_opnd[c] <= s1_ldata[c];
         endcase
      end
   end

   // Next accumulator value for each selected channel; STORE and unselected channels hold
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         acc_next[c] = acc[c];
         if (s2_valid && s2_mask[c]) begin
            case (s2_op)
               OP_MACC:  acc_next[c] = acc[c] + s2_opnd[c];
               OP_MACCZ: acc_next[c] = s2_opnd[c];
               OP_MMAX:  acc_next[c] = (s2_opnd[c] > acc[c]) ? s2_opnd[c] : acc[c];
               OP_MMAXZ: acc_next[c] = s2_opnd[c];
               OP_LDSET: acc_next[c] = s2_opnd[c];
               OP_LDADD: acc_next[c] = acc[c] + s2_opnd[c];
               OP_LDMAX: acc_next[c] = (s2_opnd[c] > acc[c]) ? s2_opnd[c] : acc[c];
               default:  acc_next[c] = acc[c];
            endcase
         end
      end
   end

   // Accumulator register bank
   always_ff @(posedge clock) begin
      for (int c = 0; c < NCH; c++) begin
         if (reset) acc[c] <= '0;
         else       acc[c] <= acc_next[c];
      end
   end

   // STORE result: shift, saturate to int8, optional relu, zero for unselected channels
   always_comb begin
      store_bytes = '0;
      shifted     = '0;
      for (int c = 0; c < NCH; c++) begin
         shifted = acc[c] >>> s2_shift;
         if (s2_mask[c]) begin
            if (shifted > 32'sd127)       store_bytes[8*c +: 8] = 8'h7F;
            else if (shifted < -32'sd128) store_bytes[8*c +: 8] = 8'h80;
            else                          store_bytes[8*c +: 8] = shifted[7:0];
            if (s2_relu && shifted < 0)   store_bytes[8*c +: 8] = 8'h00;
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_data[wr_ptr] <= store_bytes;
         fifo_mask[wr_ptr] <= s2_mask;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end
endmodule
